// File: rtl/da2_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : da2_stream
// Purpose  : Pmod DA2 driver. Serialises one 16-bit DAC121S101 frame per
//            channel ({2'b00, mode, value}, MSB first), generates its own
//            SCLK, and supports single-shot, continuous and one-deep pending
//            frame requests.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            value_a/b  - 12-bit channel codes (B ignored when CHANNELS=1)
//            mode_a/b   - 2-bit power-down bits per channel
//            update     - request one frame (sampled every clk)
//            continuous - while high, frames repeat back-to-back
//            busy       - high from SYNC fall through the done cycle
//            done       - one-clk pulse on the last gap cycle of a frame
//            SCLK       - serial clock, idles high
//            SYNC       - frame select, active low
//            SDATA_A/B  - serial data (SDATA_B constant 0 when CHANNELS=1)
// Revision : 1.0 - initial release
// ============================================================================
module da2_stream #(
  parameter int CLK_DIV    = 2,
  parameter int CHANNELS   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] value_a,
  input  logic [11:0] value_b,
  input  logic [1:0]  mode_a,
  input  logic [1:0]  mode_b,
  input  logic        update,
  input  logic        continuous,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        SYNC,
  output logic        SDATA_A,
  output logic        SDATA_B
);

  localparam logic [7:0] H_LAST   = 8'(CLK_DIV - 1);
  localparam int         GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  // Gap count one before the last; done is registered, so it is set here.
  localparam logic [GW-1:0] GAP_PRE  = GW'(GAP_CYCLES - 2);
  localparam bit         HAS_B    = (CHANNELS > 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [7:0]    half_q;     // clk count within one SCLK half-period
  logic [4:0]    ph_q;       // SCLK half-period index 0..31 within a frame
  logic [GW-1:0] gap_q;
  logic [15:0]   sr_a_q;
  logic [15:0]   sr_b_q;
  logic          pending_q;
  logic          busy_q;
  logic          done_q;
  logic          sclk_q;
  logic          sync_q;
  logic          sda_q;
  logic          sdb_q;

  logic          start_req_d;
  logic          load_d;
  logic [15:0]   word_a_d;
  logic [15:0]   word_b_d;

  always_comb begin
    start_req_d = update | pending_q | continuous;
    // A frame starts from IDLE or straight out of the last gap cycle.
    load_d      = start_req_d &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_GAP) && (gap_q == GAP_LAST)));
    word_a_d    = {2'b00, mode_a, value_a};
    word_b_d    = HAS_B ? {2'b00, mode_b, value_b} : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      half_q    <= 8'd0;
      ph_q      <= 5'd0;
      gap_q     <= '0;
      sr_a_q    <= 16'h0000;
      sr_b_q    <= 16'h0000;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b1;
      sync_q    <= 1'b1;
      sda_q     <= 1'b0;
      sdb_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // busy_q also covers the done cycle, so an update there is queued.
      if (update && busy_q) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
        end

        S_SHIFT: begin
          if (half_q == H_LAST) begin
            half_q <= 8'd0;
            if (ph_q == 5'd31) begin
              state_q <= S_GAP;
              sync_q  <= 1'b1;
              sclk_q  <= 1'b1;
              sda_q   <= 1'b0;
              sdb_q   <= 1'b0;
              gap_q   <= '0;
              done_q  <= (GAP_CYCLES == 1);
            end else begin
              ph_q   <= ph_q + 5'd1;
              sclk_q <= ~sclk_q;
              // Data advances on SCLK rising edges only.
              if (!sclk_q) begin
                sr_a_q <= {sr_a_q[14:0], 1'b0};
                sr_b_q <= {sr_b_q[14:0], 1'b0};
                sda_q  <= sr_a_q[14];
                sdb_q  <= sr_b_q[14];
              end
            end
          end else begin
            half_q <= half_q + 8'd1;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (!start_req_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q  <= gap_q + GW'(1);
            done_q <= (gap_q == GAP_PRE);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          sync_q  <= 1'b1;
          sclk_q  <= 1'b1;
          sda_q   <= 1'b0;
          sdb_q   <= 1'b0;
        end
      endcase

      // Frame start: inputs latched here and nowhere else.
      if (load_d) begin
        state_q   <= S_SHIFT;
        sync_q    <= 1'b0;
        sclk_q    <= 1'b1;
        busy_q    <= 1'b1;
        pending_q <= 1'b0;
        half_q    <= 8'd0;
        ph_q      <= 5'd0;
        sr_a_q    <= word_a_d;
        sr_b_q    <= word_b_d;
        sda_q     <= word_a_d[15];
        sdb_q     <= word_b_d[15];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk_q;
  assign SYNC    = sync_q;
  assign SDATA_A = sda_q;
  assign SDATA_B = sdb_q;

endmodule
`default_nettype wire
